mem_a_skew: RTL

- Parametrised successor to the systolic-array A-operand buffer: holds a DIM x K tile of matrix A and streams it into the array's left edge.
- Row-wise loading as before, plus a built-in diagonal skew on output: row i is delayed i cycles, so no external skew registers are needed.
- Adds a start/busy/done handshake, a per-stream recirculate mode that keeps the tile for reuse, and write-conflict reporting.
- Sits between the host load path and the systolic array's A inputs.

---
 rtl/mem_a_skew.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_a_skew.sv
// Systolic-array A-operand tile buffer with built-in diagonal output skew.
// Ports: clk, rst (async, active-high); wr_en/wr_row/wr_data load one row
// of K elements while idle; go/recirc start a stream (recirc keeps the
// tile afterwards); busy/done handshake; wr_err flags rejected writes;
// a_valid/a_out carry the skewed rows (row i at a_out[i*BITS_AB +: BITS_AB]).
module mem_a_skew #(
   parameter int BITS_AB = 32,
   parameter int DIM     = 8,
   parameter int K       = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [$clog2(DIM)-1:0]   wr_row,
   input  logic [K*BITS_AB-1:0]     wr_data,
   input  logic                     go,
   input  logic                     recirc,
   output logic                     busy,
   output logic                     done,
   output logic                     wr_err,
   output logic                     a_valid,
   output logic [DIM*BITS_AB-1:0]   a_out
);

   localparam int RW = $clog2(DIM);
   localparam int TW = $clog2(DIM + K);
   localparam logic [TW-1:0] T_LAST = TW'(DIM + K - 2);
   localparam logic [RW:0]   DIM_W  = (RW + 1)'(DIM);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [BITS_AB-1:0]   mem_q [DIM][K];
   logic [BITS_AB-1:0]   mem_d [DIM][K];
   logic [DIM-1:0]       loaded_q, loaded_d;
   logic [TW-1:0]        t_q, t_d;
   logic                 recirc_q, recirc_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 wr_err_q, wr_err_d;
   logic                 a_valid_q, a_valid_d;
   logic [DIM*BITS_AB-1:0] a_out_q, a_out_d;
   logic                 row_ok;

   // Only reachable when DIM is not a power of two.
   assign row_ok = ({1'b0, wr_row} < DIM_W);

   always_comb begin
      state_d  = state_q;
      mem_d    = mem_q;
      loaded_d = loaded_q;
      t_d      = t_q;
      recirc_d = recirc_q;
      done_d   = 1'b0;
      wr_err_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (go) begin
               // go wins over a simultaneous write; the write is dropped.
               recirc_d = recirc;
               t_d      = '0;
               state_d  = STREAM;
               wr_err_d = wr_en;
            end else if (wr_en) begin
               if (row_ok) begin
                  for (int r = 0; r < DIM; r++) begin
                     if (wr_row == RW'(r)) begin
                        for (int j = 0; j < K; j++) begin
                           mem_d[r][j] = wr_data[j*BITS_AB +: BITS_AB];
                        end
                        loaded_d[r] = 1'b1;
                     end
                  end
               end else begin
                  wr_err_d = 1'b1;
               end
            end
         end
         STREAM: begin
            wr_err_d = wr_en;
            if (t_q == T_LAST) begin
               state_d = DONE;
            end else begin
               t_d = t_q + 1'b1;
            end
         end
         DONE: begin
            wr_err_d = wr_en;
            done_d   = 1'b1;
            state_d  = IDLE;
            t_d      = '0;
            if (!recirc_q) begin
               for (int r = 0; r < DIM; r++) begin
                  for (int j = 0; j < K; j++) begin
                     mem_d[r][j] = '0;
                  end
               end
               loaded_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Held high through the done cycle, which falls after DONE.
      busy_d = (state_d != IDLE) | done_d;
   end

   // Row i at step t shows column t-i; matching t against i+j avoids
   // a subtraction and the negative-index case.
   always_comb begin
      a_valid_d = (state_q == STREAM);
      a_out_d   = '0;
      if (state_q == STREAM) begin
         for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < K; j++) begin
               if (loaded_q[i] && (t_q == TW'(i + j))) begin
                  a_out_d[i*BITS_AB +: BITS_AB] = mem_q[i][j];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         loaded_q  <= '0;
         t_q       <= '0;
         recirc_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         wr_err_q  <= 1'b0;
         a_valid_q <= 1'b0;
         a_out_q   <= '0;
         for (int r = 0; r < DIM; r++) begin
            for (int j = 0; j < K; j++) begin
               mem_q[r][j] <= '0;
            end
         end
      end else begin
         state_q   <= state_d;
         loaded_q  <= loaded_d;
         t_q       <= t_d;
         recirc_q  <= recirc_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         wr_err_q  <= wr_err_d;
         a_valid_q <= a_valid_d;
         a_out_q   <= a_out_d;
         for (int r = 0; r < DIM; r++) begin
            for (int j = 0; j < K; j++) begin
               mem_q[r][j] <= mem_d[r][j];
            end
         end
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign wr_err  = wr_err_q;
   assign a_valid = a_valid_q;
   assign a_out   = a_out_q;

endmodule
